// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the SDRAM memory controller and its SPART write feeder.
// The busy status codes live here so the controller and the packer agree on them.
package mem_ctrl_pkg;

  // Controller status as reported on the 2-bit busy bus
  typedef enum logic [1:0] {
    FREE       = 2'b00,
    BUSY_CPU   = 2'b01,
    BUSY_SPART = 2'b10,
    BUSY_AUDIO = 2'b11
  } mem_busy_e;

  // Write-issue states of the SPART packer
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    DRAIN = 2'b10
  } packer_state_e;

  // Byte and word widths used by the packer datapath
  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  // Busy code that tells the packer its request has been taken
  function automatic logic is_spart_ack(input logic [1:0] busy);
    return busy == BUSY_SPART;
  endfunction

endpackage

// File: rtl/spart_wr_packer_sync_fifo.sv
// Synchronous circular-buffer FIFO used by the SPART write packer.
// Pointers carry one extra wrap bit so full and empty are told apart without
// a separate counter; the head word is read combinationally.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  // Depth must be a power of two so the pointers wrap on their own
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             wr_en;
  logic             rd_en;

  // Status flags and the acceptance rule: a push into a full FIFO still
  // succeeds when the head leaves in the same cycle
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    rd_en = pop && !empty;
    wr_en = push && (!full || rd_en);
    level = wr_ptr_q - rd_ptr_q;
    dout  = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Next pointer values and storage write
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (wr_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers; reset empties the buffer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/spart_wr_packer.sv
// SPART write packer: pairs received UART bytes into 16-bit words, buffers
// them, and hands them one at a time to the memory controller's SPART port
// whenever the controller reports itself free.
// Optional macro SPART_PAD_TIMEOUT_EN: a lone byte that waits TIMEOUT idle
// cycles is padded with a zero high byte and pushed on its own.
module spart_wr_packer
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic [1:0]             mem_busy,
  output logic [15:0]            mem_wdata,
  output logic                   mem_wr,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  input  logic                   clr_ovf
);

  // A zero timeout would pad every byte immediately
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("spart_wr_packer: TIMEOUT must be at least 1");
  end

  logic                 pending_q, pending_d;
  logic [BYTE_W-1:0]    low_q, low_d;
  logic                 push_req;
  logic [WORD_W-1:0]    push_word;

  packer_state_e        state_q, state_d;
  logic                 wr_q, wr_d;
  logic [WORD_W-1:0]    wdata_q, wdata_d;
  logic                 pop;

  logic                 ovf_q, ovf_d;
  logic                 drop;

  logic [WORD_W-1:0]    fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;

`ifdef SPART_PAD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]        cnt_q, cnt_d;

  // Byte pairing, with a zero-padded push once a lone byte has waited long enough;
  // a real partner byte always wins over the timeout
  always_comb begin
    pending_d = pending_q;
    low_d     = low_q;
    push_req  = 1'b0;
    push_word = {rx_data, low_q};
    cnt_d     = cnt_q;
    if (rx_valid) begin
      cnt_d = '0;
      if (pending_q) begin
        push_req  = 1'b1;
        pending_d = 1'b0;
      end else begin
        low_d     = rx_data;
        pending_d = 1'b1;
      end
    end else if (!pending_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
      push_req  = 1'b1;
      push_word = {8'h00, low_q};
      pending_d = 1'b0;
      cnt_d     = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Idle-cycle counter for the lone pending byte
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Byte pairing: the first byte is parked as the low half, the second
  // completes the word and is pushed in the same cycle
  always_comb begin
    pending_d = pending_q;
    low_d     = low_q;
    push_req  = 1'b0;
    push_word = {rx_data, low_q};
    if (rx_valid) begin
      if (pending_q) begin
        push_req  = 1'b1;
        pending_d = 1'b0;
      end else begin
        low_d     = rx_data;
        pending_d = 1'b1;
      end
    end
  end
`endif

  // Pending-byte registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      low_q     <= '0;
    end else begin
      pending_q <= pending_d;
      low_q     <= low_d;
    end
  end

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .pop   (pop),
    .din   (push_word),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Issue handshake: request only when the controller is free, hold the
  // request through CPU/audio service, and release it once the controller
  // reports it is serving us; then wait for free again before the next word
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        wr_d = 1'b0;
        if (!fifo_empty && mem_busy == FREE) begin
          state_d = ISSUE;
          wr_d    = 1'b1;
          wdata_d = fifo_dout;
        end
      end
      ISSUE: begin
        wr_d = 1'b1;
        if (is_spart_ack(mem_busy)) begin
          state_d = DRAIN;
          wr_d    = 1'b0;
          pop     = 1'b1;
        end
      end
      DRAIN: begin
        wr_d = 1'b0;
        if (mem_busy == FREE) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        wr_d    = 1'b0;
      end
    endcase
  end

  // Handshake registers; outputs come straight from flops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
    end
  end

  // Sticky overflow: a drop in the same cycle as a clear keeps it set
  always_comb begin
    drop  = push_req && fifo_full && !pop;
    ovf_d = ovf_q;
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  // Overflow flag register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign mem_wr    = wr_q;
  assign mem_wdata = wdata_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_spart_wr_packer.sv
// Self-checking bench for spart_wr_packer: a table of directed cycles, hand
// sequences for overflow, full push/pop, reset and pad timeout, then random
// traffic, all compared every cycle against a queue-based reference model.
module tb_spart_wr_packer;

  localparam int TB_DEPTH   = 16;
  localparam int TB_TIMEOUT = 8;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [1:0]  mem_busy;
  logic [15:0] mem_wdata;
  logic        mem_wr;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic        clr_ovf;

  int nCompared;
  int nMismatched;

  spart_wr_packer #(
    .DEPTH   (TB_DEPTH),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .mem_busy   (mem_busy),
    .mem_wdata  (mem_wdata),
    .mem_wr     (mem_wr),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: words as a queue, one pending byte, and the request
  // protocol as two flags (a request is outstanding / waiting for free)
  logic [15:0] mq[$];
  bit          mPend;
  logic [7:0]  mLow;
  bit          mOut;
  bit          mWait;
  logic [15:0] mWdata;
  bit          mOvf;
  int          mIdle;

  task automatic check(input string name, input int act, input int exp);
    nCompared++;
    if (act != exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    bit          popNow;
    bit          startNow;
    bit          have;
    bit          dropNow;
    logic [15:0] w;
    if (!rst_n) begin
      mq.delete();
      mPend  = 0;
      mLow   = 8'h00;
      mOut   = 0;
      mWait  = 0;
      mWdata = 16'h0000;
      mOvf   = 0;
      mIdle  = 0;
      return;
    end
    popNow   = mOut && (mem_busy == 2'b10);
    startNow = !mOut && !mWait && (mq.size() > 0) && (mem_busy == 2'b00);
    if (startNow) mWdata = mq[0];
    have = 0;
    w    = 16'h0000;
    if (rx_valid) begin
      mIdle = 0;
      if (mPend) begin
        w = {rx_data, mLow};
        have = 1;
        mPend = 0;
      end else begin
        mLow  = rx_data;
        mPend = 1;
      end
    end else if (mPend) begin
`ifdef SPART_PAD_TIMEOUT_EN
      mIdle++;
      if (mIdle == TB_TIMEOUT) begin
        w = {8'h00, mLow};
        have = 1;
        mPend = 0;
        mIdle = 0;
      end
`endif
    end
    dropNow = have && (mq.size() == TB_DEPTH) && !popNow;
    if (clr_ovf) mOvf = 0;
    if (dropNow) mOvf = 1;
    if (popNow) void'(mq.pop_front());
    if (have && !dropNow) mq.push_back(w);
    if (popNow) begin
      mOut  = 0;
      mWait = 1;
    end else if (startNow) begin
      mOut = 1;
    end else if (mWait && mem_busy == 2'b00) begin
      mWait = 0;
    end
  endtask

  task automatic checkOutput();
    check("model_mem_wr", int'(mem_wr), int'(mOut));
    check("model_level", int'(fifo_level), mq.size());
    check("model_overflow", int'(overflow), int'(mOvf));
    check("model_wdata", int'(mem_wdata), int'(mWdata));
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d,
                               input logic [1:0] b, input logic c);
    rx_valid = v;
    rx_data  = d;
    mem_busy = b;
    clr_ovf  = c;
    tick();
  endtask

  typedef struct {
    logic        rv;
    logic [7:0]  rd;
    logic [1:0]  busy;
    logic [15:0] expWdata;
    logic        expWr;
    int          expLevel;
    string       name;
  } vec_t;

  function automatic vec_t mkVec(input logic rv, input logic [7:0] rd, input logic [1:0] busy,
                                 input logic [15:0] ew, input logic ewr, input int el,
                                 input string nm);
    vec_t v;
    v.rv = rv; v.rd = rd; v.busy = busy;
    v.expWdata = ew; v.expWr = ewr; v.expLevel = el; v.name = nm;
    return v;
  endfunction

  function automatic logic [7:0] ovfByte(input int i);
    return 8'((i * 37 + 5) & 255);
  endfunction

  function automatic logic [15:0] ovfWord(input int k);
    return {ovfByte(2 * k + 1), ovfByte(2 * k)};
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t        vecs[$];
    logic [15:0] expQ[$];
    int          si;
    int          r;
    logic [1:0]  rb;

    nCompared   = 0;
    nMismatched = 0;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    mem_busy = 2'b00;
    clr_ovf  = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 2'b00, 1'b0);
    check("reset_mem_wr", int'(mem_wr), 0);
    check("reset_wdata", int'(mem_wdata), 0);
    check("reset_level", int'(fifo_level), 0);
    check("reset_overflow", int'(overflow), 0);

    // Directed cycles: basic pack/issue/accept, then CPU and audio busy
    vecs.push_back(mkVec(1, 8'h34, 2'b00, 16'h0000, 0, 0, "pair_lo"));
    vecs.push_back(mkVec(1, 8'h12, 2'b00, 16'h0000, 0, 1, "pair_hi"));
    vecs.push_back(mkVec(0, 8'h00, 2'b00, 16'h1234, 1, 1, "issue"));
    vecs.push_back(mkVec(0, 8'h00, 2'b10, 16'h0000, 0, 0, "accept"));
    vecs.push_back(mkVec(0, 8'h00, 2'b10, 16'h0000, 0, 0, "drain_hold"));
    vecs.push_back(mkVec(0, 8'h00, 2'b00, 16'h0000, 0, 0, "drain_exit"));
    vecs.push_back(mkVec(1, 8'h78, 2'b01, 16'h0000, 0, 0, "cpu_lo"));
    vecs.push_back(mkVec(1, 8'h56, 2'b01, 16'h0000, 0, 1, "cpu_hi"));
    vecs.push_back(mkVec(0, 8'h00, 2'b01, 16'h0000, 0, 1, "cpu_wait1"));
    vecs.push_back(mkVec(0, 8'h00, 2'b01, 16'h0000, 0, 1, "cpu_wait2"));
    vecs.push_back(mkVec(0, 8'h00, 2'b00, 16'h5678, 1, 1, "free_issue"));
    vecs.push_back(mkVec(0, 8'h00, 2'b11, 16'h5678, 1, 1, "audio_hold1"));
    vecs.push_back(mkVec(0, 8'h00, 2'b11, 16'h5678, 1, 1, "audio_hold2"));
    vecs.push_back(mkVec(0, 8'h00, 2'b10, 16'h0000, 0, 0, "spart_accept"));
    vecs.push_back(mkVec(0, 8'h00, 2'b00, 16'h0000, 0, 0, "back_idle"));
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rv, vecs[i].rd, vecs[i].busy, 1'b0);
      check({vecs[i].name, "_wr"}, int'(mem_wr), int'(vecs[i].expWr));
      check({vecs[i].name, "_level"}, int'(fifo_level), vecs[i].expLevel);
      if (vecs[i].expWr) check({vecs[i].name, "_wdata"}, int'(mem_wdata), int'(vecs[i].expWdata));
    end

    // Overflow: 34 bytes with audio holding the controller
    for (int i = 0; i < 34; i++) applyStimulus(1'b1, ovfByte(i), 2'b11, 1'b0);
    check("ovf_level_full", int'(fifo_level), 16);
    check("ovf_sticky_set", int'(overflow), 1);
    applyStimulus(1'b0, 8'h00, 2'b11, 1'b1);
    check("ovf_cleared", int'(overflow), 0);

    // Full FIFO: push and acceptance in the same cycle
    applyStimulus(1'b1, 8'hA1, 2'b11, 1'b0);
    applyStimulus(1'b0, 8'h00, 2'b00, 1'b0);
    check("full_issue_wr", int'(mem_wr), 1);
    check("full_issue_head", int'(mem_wdata), int'(ovfWord(0)));
    applyStimulus(1'b1, 8'hB2, 2'b10, 1'b0);
    check("full_pushpop_level", int'(fifo_level), 16);
    check("full_pushpop_ovf", int'(overflow), 0);

    // Drain everything while streaming more words through the pointer wrap
    for (int k = 1; k < 16; k++) expQ.push_back(ovfWord(k));
    expQ.push_back(16'hB2A1);
    si = 0;
    for (int cyc = 0; cyc < 300 && expQ.size() > 0; cyc++) begin
      logic       v;
      logic [7:0] d;
      v = 1'b0;
      d = 8'h00;
      if (cyc >= 12 && si < 8) begin
        v = 1'b1;
        d = 8'(8'hC0 + si);
        si++;
        if (si % 2 == 0) expQ.push_back({8'(8'hC0 + si - 1), 8'(8'hC0 + si - 2)});
      end
      if (mem_wr) begin
        check("drain_order", int'(mem_wdata), int'(expQ.pop_front()));
        applyStimulus(v, d, 2'b10, 1'b0);
      end else begin
        applyStimulus(v, d, 2'b00, 1'b0);
      end
    end
    check("drain_left", expQ.size(), 0);
    applyStimulus(1'b0, 8'h00, 2'b00, 1'b0);
    applyStimulus(1'b0, 8'h00, 2'b00, 1'b0);

    // Reset in the middle of a handshake with a byte pending
    applyStimulus(1'b1, 8'h11, 2'b00, 1'b0);
    applyStimulus(1'b1, 8'h22, 2'b00, 1'b0);
    applyStimulus(1'b0, 8'h00, 2'b00, 1'b0);
    check("pre_reset_issue", int'(mem_wr), 1);
    applyStimulus(1'b1, 8'h33, 2'b11, 1'b0);
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 2'b11, 1'b0);
    rst_n = 1'b1;
    check("midreset_wr", int'(mem_wr), 0);
    check("midreset_level", int'(fifo_level), 0);
    applyStimulus(1'b1, 8'hCD, 2'b11, 1'b0);
    applyStimulus(1'b1, 8'hEF, 2'b11, 1'b0);
    check("postreset_level", int'(fifo_level), 1);
    applyStimulus(1'b0, 8'h00, 2'b00, 1'b0);
    check("postreset_word", int'(mem_wdata), 16'hEFCD);
    applyStimulus(1'b0, 8'h00, 2'b10, 1'b0);
    applyStimulus(1'b0, 8'h00, 2'b00, 1'b0);
    applyStimulus(1'b0, 8'h00, 2'b00, 1'b0);

    // Lone byte followed by silence
    applyStimulus(1'b1, 8'hAB, 2'b11, 1'b0);
    for (int i = 0; i < 100; i++) applyStimulus(1'b0, 8'h00, 2'b11, 1'b0);
`ifdef SPART_PAD_TIMEOUT_EN
    check("pad_level", int'(fifo_level), 1);
    applyStimulus(1'b0, 8'h00, 2'b00, 1'b0);
    check("pad_word", int'(mem_wdata), 16'h00AB);
`else
    check("nopad_level", int'(fifo_level), 0);
    applyStimulus(1'b1, 8'hCC, 2'b11, 1'b0);
    applyStimulus(1'b0, 8'h00, 2'b00, 1'b0);
    check("late_pair_word", int'(mem_wdata), 16'hCCAB);
`endif
    applyStimulus(1'b0, 8'h00, 2'b10, 1'b0);
    applyStimulus(1'b0, 8'h00, 2'b00, 1'b0);
    applyStimulus(1'b0, 8'h00, 2'b00, 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 9);
      rb = (r < 4) ? 2'b00 : (r < 6) ? 2'b01 : (r < 8) ? 2'b10 : 2'b11;
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), rb,
                    1'($urandom_range(0, 19) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
